// File: rtl/clock_edge_monitor_pkg.sv
// Shared types and helpers for the slow-clock edge monitor.
// State encoding, default parameters and a saturating increment.
package clock_edge_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 64;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] value,
        input logic [63:0] max
    );
        return (value >= max) ? max : value + 64'd1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Chain depth is a parameter; every stage clears on clr.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clock_edge_monitor.sv
// Edge strobes, period/high-time measurement and stall detection
// for a divided clock sampled in the fast clkin domain.
module clock_edge_monitor
    import clock_edge_monitor_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clkin,
    input  logic             clr,
    input  logic             slowclk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             stalled
);

    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0]    PRIME_END = PW'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             sync;
    logic             prev;
    logic [PW-1:0]    prime_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cap;
    logic             primed;
    logic             rise;
    logic             fall;
    logic             timeout;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clkin),
        .clr (clr),
        .d   (slowclk),
        .q   (sync)
    );

    // Edges are only trusted once the chain and prev hold real samples.
    assign primed  = (prime_cnt == PRIME_END);
    assign rise    = primed & sync & ~prev;
    assign fall    = primed & ~sync & prev;
    assign cap     = CNT_W'(sat_inc(64'(cnt), 64'(CNT_MAX)));
    assign timeout = (cnt == TO_LAST);

    // Prime window, edge history and registered strobes.
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            prev       <= 1'b0;
            prime_cnt  <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            prev       <= sync;
            rise_pulse <= rise;
            fall_pulse <= fall;
            if (!primed) begin
                prime_cnt <= prime_cnt + PW'(1);
            end
        end
    end

    // Measurement FSM: counter, captures and status flags.
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    cnt <= rise ? '0 : cap;
                    if (fall) begin
                        high_time <= cap;
                    end
                    if (rise) begin
                        state        <= LOCKED;
                        period       <= cap;
                        period_valid <= 1'b1;
                    end else if (timeout) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                    end
                end
                LOCKED: begin
                    cnt <= rise ? '0 : cap;
                    if (fall) begin
                        high_time <= cap;
                    end
                    if (rise) begin
                        period <= cap;
                    end else if (timeout) begin
                        state        <= STALLED;
                        stalled      <= 1'b1;
                        period_valid <= 1'b0;
                    end
                end
                STALLED: begin
                    cnt <= rise ? '0 : cap;
                    if (rise) begin
                        state   <= ARMED;
                        stalled <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
